// File: rtl/asmi_flash_responder.sv
// SPI (mode 0/3) serial-flash responder for the ASMI active-serial interface.
// Oversamples the SPI pins in the system clock domain and serves a byte-wide memory port.
module asmi_flash_responder #(
    parameter int unsigned ADDR_W       = 24,
    parameter logic [7:0]  DEVICE_ID    = 8'h18,
    parameter int unsigned DUMMY_CYCLES = 8
) (
    input  logic              clk_sys_i,
    input  logic              rst_n_i,
    input  logic              sclk_i,
    input  logic              ncs_i,
    input  logic              mosi_i,
    output logic              miso_o,
    output logic              miso_oe_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_rd_o,
    input  logic [7:0]        mem_rdata_i,
    output logic              mem_wr_o,
    output logic [7:0]        mem_wdata_o,
    output logic              erase_o,
    input  logic              busy_i
);

    localparam int unsigned DC_W = (DUMMY_CYCLES > 2) ? $clog2(DUMMY_CYCLES) : 1;

    localparam logic [7:0] OP_WREN  = 8'h06;
    localparam logic [7:0] OP_WRDI  = 8'h04;
    localparam logic [7:0] OP_RDSR  = 8'h05;
    localparam logic [7:0] OP_RDID  = 8'h9F;
    localparam logic [7:0] OP_EN4B  = 8'hB7;
    localparam logic [7:0] OP_EX4B  = 8'hE9;
    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_FREAD = 8'h0B;
    localparam logic [7:0] OP_PP    = 8'h02;
    localparam logic [7:0] OP_SE    = 8'hD8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DUMMY,
        S_DOUT,
        S_DIN,
        S_IGNORE
    } state_t;

    // Source of the byte reloaded after each launched byte in DOUT
    typedef enum logic [1:0] {
        K_MEM,
        K_STATUS,
        K_ID
    } kind_t;

    logic [1:0] sclk_sync;
    logic [1:0] ncs_sync;
    logic [1:0] mosi_sync;
    logic       sclk_q;

    logic       sclk_rise;
    logic       sclk_fall;
    logic       ncs_hi;
    logic       mosi_bit;
    logic [7:0] rx_byte;

    state_t            state;
    kind_t             kind;
    logic [7:0]        opcode;
    logic [2:0]        bit_cnt;
    logic [2:0]        out_cnt;
    logic [1:0]        byte_cnt;
    logic [DC_W-1:0]   dummy_cnt;
    logic [6:0]        shift_in;
    logic [7:0]        out_byte;
    logic              rd_dly;
    logic              wel;
    logic              addr4;
    logic              erase_armed;
    logic              wel_clr;

    // Two-flop synchronizers; sclk_q is the delayed copy for edge detection
    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sclk_sync <= 2'b00;
            ncs_sync  <= 2'b11;
            mosi_sync <= 2'b00;
            sclk_q    <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[0], sclk_i};
            ncs_sync  <= {ncs_sync[0], ncs_i};
            mosi_sync <= {mosi_sync[0], mosi_i};
            sclk_q    <= sclk_sync[1];
        end
    end

    assign sclk_rise = sclk_sync[1] & ~sclk_q;
    assign sclk_fall = ~sclk_sync[1] & sclk_q;
    assign ncs_hi    = ncs_sync[1];
    assign mosi_bit  = mosi_sync[1];
    assign rx_byte   = {shift_in, mosi_bit};

    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= S_IDLE;
            kind        <= K_MEM;
            opcode      <= 8'h00;
            bit_cnt     <= 3'd0;
            out_cnt     <= 3'd0;
            byte_cnt    <= 2'd0;
            dummy_cnt   <= '0;
            shift_in    <= 7'd0;
            out_byte    <= 8'h00;
            rd_dly      <= 1'b0;
            wel         <= 1'b0;
            addr4       <= 1'b0;
            erase_armed <= 1'b0;
            wel_clr     <= 1'b0;
            miso_o      <= 1'b0;
            miso_oe_o   <= 1'b0;
            mem_addr_o  <= '0;
            mem_rd_o    <= 1'b0;
            mem_wr_o    <= 1'b0;
            mem_wdata_o <= 8'h00;
            erase_o     <= 1'b0;
        end else begin
            mem_rd_o <= 1'b0;
            mem_wr_o <= 1'b0;
            erase_o  <= 1'b0;
            rd_dly   <= mem_rd_o;

            // Read data arrives one cycle after the strobe
            if (rd_dly) begin
                out_byte <= mem_rdata_i;
            end
            // Page-program address advances after each write, page-local
            if (mem_wr_o) begin
                mem_addr_o[7:0] <= mem_addr_o[7:0] + 8'd1;
            end

            if (ncs_hi) begin
                // Deselect: commit armed erase / WEL clear once, then abort everything
                if (state != S_IDLE) begin
                    erase_o <= erase_armed && (bit_cnt == 3'd0);
                    if (wel_clr) begin
                        wel <= 1'b0;
                    end
                end
                state       <= S_IDLE;
                miso_oe_o   <= 1'b0;
                bit_cnt     <= 3'd0;
                out_cnt     <= 3'd0;
                erase_armed <= 1'b0;
                wel_clr     <= 1'b0;
            end else begin
                if (sclk_rise) begin
                    bit_cnt  <= bit_cnt + 3'd1;
                    shift_in <= rx_byte[6:0];
                end

                case (state)
                    S_IDLE: begin
                        state   <= S_CMD;
                        bit_cnt <= 3'd0;
                        out_cnt <= 3'd0;
                    end

                    S_CMD: begin
                        if (sclk_rise && bit_cnt == 3'd7) begin
                            byte_cnt <= 2'd0;
                            state    <= S_IGNORE;
                            case (rx_byte)
                                OP_WREN: wel   <= 1'b1;
                                OP_WRDI: wel   <= 1'b0;
                                OP_EN4B: addr4 <= 1'b1;
                                OP_EX4B: addr4 <= 1'b0;
                                OP_RDSR: begin
                                    kind     <= K_STATUS;
                                    out_byte <= {6'b0, wel, busy_i};
                                    state    <= S_DOUT;
                                end
                                OP_RDID: begin
                                    kind     <= K_ID;
                                    out_byte <= DEVICE_ID;
                                    state    <= S_DOUT;
                                end
                                OP_READ, OP_FREAD: begin
                                    kind       <= K_MEM;
                                    opcode     <= rx_byte;
                                    mem_addr_o <= '0;
                                    state      <= S_ADDR;
                                end
                                OP_PP, OP_SE: begin
                                    if (wel) begin
                                        opcode     <= rx_byte;
                                        wel_clr    <= 1'b1;
                                        mem_addr_o <= '0;
                                        state      <= S_ADDR;
                                    end
                                end
                                default: state <= S_IGNORE;
                            endcase
                        end
                    end

                    S_ADDR: begin
                        if (sclk_rise) begin
                            // Bits above ADDR_W fall off the top of the shift
                            mem_addr_o <= {mem_addr_o[ADDR_W-2:0], mosi_bit};
                            if (bit_cnt == 3'd7) begin
                                byte_cnt <= byte_cnt + 2'd1;
                                if (byte_cnt == (addr4 ? 2'd3 : 2'd2)) begin
                                    case (opcode)
                                        OP_READ: begin
                                            mem_rd_o <= 1'b1;
                                            state    <= S_DOUT;
                                        end
                                        OP_FREAD: begin
                                            dummy_cnt <= '0;
                                            if (DUMMY_CYCLES == 0) begin
                                                mem_rd_o <= 1'b1;
                                                state    <= S_DOUT;
                                            end else begin
                                                state <= S_DUMMY;
                                            end
                                        end
                                        OP_PP: state <= S_DIN;
                                        OP_SE: begin
                                            erase_armed <= 1'b1;
                                            state       <= S_IGNORE;
                                        end
                                        default: state <= S_IGNORE;
                                    endcase
                                end
                            end
                        end
                    end

                    S_DUMMY: begin
                        if (sclk_rise) begin
                            dummy_cnt <= dummy_cnt + DC_W'(1);
                            if (dummy_cnt == DC_W'(DUMMY_CYCLES - 1)) begin
                                mem_rd_o <= 1'b1;
                                state    <= S_DOUT;
                            end
                        end
                    end

                    S_DOUT: begin
                        if (sclk_fall) begin
                            miso_oe_o <= 1'b1;
                            miso_o    <= out_byte[3'd7 - out_cnt];
                            out_cnt   <= out_cnt + 3'd1;
                            // Bit 0 is on the wire: fetch the next byte
                            if (out_cnt == 3'd7) begin
                                case (kind)
                                    K_MEM: begin
                                        mem_addr_o <= mem_addr_o + ADDR_W'(1);
                                        mem_rd_o   <= 1'b1;
                                    end
                                    K_STATUS: out_byte <= {6'b0, wel, busy_i};
                                    default:  out_byte <= DEVICE_ID;
                                endcase
                            end
                        end
                    end

                    S_DIN: begin
                        if (sclk_rise && bit_cnt == 3'd7) begin
                            mem_wr_o    <= 1'b1;
                            mem_wdata_o <= rx_byte;
                        end
                    end

                    S_IGNORE: begin
                    end

                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_asmi_flash_responder.sv
// Directed bench for asmi_flash_responder: bit-banged SPI master, byte memory model,
// strobe loggers and a table of single-opcode transactions.
module tb_asmi_flash_responder;

    localparam int HALF = 60;

    logic        clk;
    logic        rst_n;
    logic        sclk;
    logic        ncs;
    logic        mosi;
    logic        miso;
    logic        miso_oe;
    logic [23:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_rdata;
    logic        mem_wr;
    logic [7:0]  mem_wdata;
    logic        erase;
    logic        busy;

    int checks;
    int errors;

    int          rd_cnt;
    int          wr_cnt;
    int          erase_cnt;
    logic [23:0] erase_addr;
    logic [23:0] rd_log    [0:63];
    logic [23:0] wr_addr_log [0:63];
    logic [7:0]  wr_data_log [0:63];

    asmi_flash_responder dut (
        .clk_sys_i   (clk),
        .rst_n_i     (rst_n),
        .sclk_i      (sclk),
        .ncs_i       (ncs),
        .mosi_i      (mosi),
        .miso_o      (miso),
        .miso_oe_o   (miso_oe),
        .mem_addr_o  (mem_addr),
        .mem_rd_o    (mem_rd),
        .mem_rdata_i (mem_rdata),
        .mem_wr_o    (mem_wr),
        .mem_wdata_o (mem_wdata),
        .erase_o     (erase),
        .busy_i      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] mem_val(input logic [23:0] a);
        case (a)
            24'hFFFFFE: mem_val = 8'hA1;
            24'hFFFFFF: mem_val = 8'hB2;
            24'h000000: mem_val = 8'hC3;
            default:    mem_val = 8'h3C ^ a[7:0] ^ a[15:8];
        endcase
    endfunction

    // Memory responds one cycle after the read strobe; loggers record all strobes
    always_ff @(posedge clk) begin
        if (mem_rd) begin
            mem_rdata           <= mem_val(mem_addr);
            rd_log[rd_cnt[5:0]] <= mem_addr;
            rd_cnt              <= rd_cnt + 1;
        end
        if (mem_wr) begin
            wr_addr_log[wr_cnt[5:0]] <= mem_addr;
            wr_data_log[wr_cnt[5:0]] <= mem_wdata;
            wr_cnt                   <= wr_cnt + 1;
        end
        if (erase) begin
            erase_addr <= mem_addr;
            erase_cnt  <= erase_cnt + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic spi_bit(input logic b, output logic r);
        mosi = b;
        #HALF;
        r = miso;
        sclk = 1'b1;
        #HALF;
        sclk = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(tx[i], b);
            rx[i] = b;
        end
    endtask

    task automatic spi_start();
        ncs = 1'b0;
        #(2 * HALF);
    endtask

    task automatic spi_end();
        #HALF;
        ncs = 1'b1;
        #(4 * HALF);
    endtask

    task automatic spi_cmd(input logic [7:0] op);
        logic [7:0] rx;
        spi_start();
        spi_byte(op, rx);
        spi_end();
    endtask

    task automatic rdsr_check(input string name, input logic [7:0] exp);
        logic [7:0] rx;
        spi_start();
        spi_byte(8'h05, rx);
        spi_byte(8'h00, rx);
        spi_end();
        check(name, 32'(rx), 32'(exp));
    endtask

    typedef struct {
        logic [7:0] op;
        logic       busy;
        int         n_rx;
        logic [7:0] exp;
        string      name;
    } vec_t;

    vec_t vecs [0:8];

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] rx;
        logic       b;
        int         r0;
        int         w0;
        int         e0;

        vecs[0] = '{8'h06, 1'b0, 0, 8'h00, "wren"};
        vecs[1] = '{8'h05, 1'b1, 1, 8'h03, "rdsr_wel_busy"};
        vecs[2] = '{8'h05, 1'b0, 2, 8'h02, "rdsr_wel"};
        vecs[3] = '{8'h04, 1'b0, 0, 8'h00, "wrdi"};
        vecs[4] = '{8'h05, 1'b0, 1, 8'h00, "rdsr_clear"};
        vecs[5] = '{8'h05, 1'b1, 1, 8'h01, "rdsr_busy_only"};
        vecs[6] = '{8'h9F, 1'b0, 3, 8'h18, "rdid"};
        vecs[7] = '{8'hAB, 1'b0, 0, 8'h00, "unknown_op"};
        vecs[8] = '{8'h05, 1'b0, 1, 8'h00, "rdsr_after_unknown"};

        rst_n = 1'b0;
        ncs   = 1'b1;
        sclk  = 1'b0;
        mosi  = 1'b0;
        busy  = 1'b0;
        #100;
        check("reset_miso", 32'(miso), 32'd0);
        check("reset_miso_oe", 32'(miso_oe), 32'd0);
        check("reset_mem_addr", 32'(mem_addr), 32'd0);
        check("reset_mem_wdata", 32'(mem_wdata), 32'd0);
        rst_n = 1'b1;
        #100;
        rdsr_check("reset_wel", 8'h00);

        // Table of single-opcode transactions
        for (int v = 0; v < 9; v++) begin
            busy = vecs[v].busy;
            spi_start();
            spi_byte(vecs[v].op, rx);
            for (int k = 0; k < vecs[v].n_rx; k++) begin
                spi_byte(8'h00, rx);
                check(vecs[v].name, 32'(rx), 32'(vecs[v].exp));
            end
            spi_end();
        end
        busy = 1'b0;

        // RDID output enable timing
        spi_start();
        check("rdid_oe_before", 32'(miso_oe), 32'd0);
        spi_byte(8'h9F, rx);
        #40;
        check("rdid_oe_first_fall", 32'(miso_oe), 32'd1);
        spi_byte(8'h00, rx);
        check("rdid_byte0", 32'(rx), 32'h18);
        spi_end();
        check("rdid_oe_after_ncs", 32'(miso_oe), 32'd0);

        // READ across the top of the address space
        r0 = rd_cnt;
        spi_start();
        spi_byte(8'h03, rx);
        spi_byte(8'hFF, rx);
        spi_byte(8'hFF, rx);
        spi_byte(8'hFE, rx);
        spi_byte(8'h00, rx);
        check("read_b0", 32'(rx), 32'hA1);
        spi_byte(8'h00, rx);
        check("read_b1", 32'(rx), 32'hB2);
        spi_byte(8'h00, rx);
        check("read_b2", 32'(rx), 32'hC3);
        spi_end();
        check("read_addr0", 32'(rd_log[r0[5:0]]), 32'hFFFFFE);
        check("read_addr1", 32'(rd_log[6'((r0 + 1) % 64)]), 32'hFFFFFF);
        check("read_addr2", 32'(rd_log[6'((r0 + 2) % 64)]), 32'h000000);

        // FAST_READ in 4-byte address mode
        spi_cmd(8'hB7);
        spi_start();
        spi_byte(8'h0B, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'h10, rx);
        spi_byte(8'h00, rx);
        r0 = rd_cnt;
        for (int i = 0; i < 7; i++) spi_bit(1'b0, b);
        check("fast_no_rd_after_7_dummy", 32'(rd_cnt - r0), 32'd0);
        spi_bit(1'b0, b);
        check("fast_rd_after_8_dummy", 32'(rd_cnt - r0), 32'd1);
        check("fast_addr", 32'(rd_log[r0[5:0]]), 32'h001000);
        spi_byte(8'h00, rx);
        check("fast_data", 32'(rx), 32'(mem_val(24'h001000)));
        spi_end();
        spi_cmd(8'hE9);

        // Page program without WREN is ignored
        w0 = wr_cnt;
        spi_start();
        spi_byte(8'h02, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'h55, rx);
        spi_end();
        check("pp_no_wren", 32'(wr_cnt - w0), 32'd0);

        // Page program wrapping inside the page
        spi_cmd(8'h06);
        w0 = wr_cnt;
        spi_start();
        spi_byte(8'h02, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'h01, rx);
        spi_byte(8'hFE, rx);
        spi_byte(8'h11, rx);
        spi_byte(8'h22, rx);
        spi_byte(8'h33, rx);
        spi_byte(8'h4B, rx);
        spi_bit(1'b1, b);
        spi_bit(1'b0, b);
        spi_end();
        check("pp_count", 32'(wr_cnt - w0), 32'd4);
        check("pp_addr0", 32'(wr_addr_log[w0[5:0]]), 32'h0001FE);
        check("pp_data0", 32'(wr_data_log[w0[5:0]]), 32'h11);
        check("pp_addr1", 32'(wr_addr_log[6'((w0 + 1) % 64)]), 32'h0001FF);
        check("pp_data1", 32'(wr_data_log[6'((w0 + 1) % 64)]), 32'h22);
        check("pp_addr2", 32'(wr_addr_log[6'((w0 + 2) % 64)]), 32'h000100);
        check("pp_data2", 32'(wr_data_log[6'((w0 + 2) % 64)]), 32'h33);
        check("pp_addr3", 32'(wr_addr_log[6'((w0 + 3) % 64)]), 32'h000101);
        rdsr_check("pp_wel_cleared", 8'h00);

        // Sector erase on a byte boundary
        spi_cmd(8'h06);
        e0 = erase_cnt;
        spi_start();
        spi_byte(8'hD8, rx);
        spi_byte(8'h03, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'h00, rx);
        spi_end();
        check("se_count", 32'(erase_cnt - e0), 32'd1);
        check("se_addr", 32'(erase_addr), 32'h030000);
        rdsr_check("se_wel_cleared", 8'h00);

        // Sector erase with trailing partial byte: no erase
        spi_cmd(8'h06);
        e0 = erase_cnt;
        spi_start();
        spi_byte(8'hD8, rx);
        spi_byte(8'h03, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'h00, rx);
        for (int i = 0; i < 3; i++) spi_bit(1'b0, b);
        spi_end();
        check("se_partial_no_erase", 32'(erase_cnt - e0), 32'd0);
        rdsr_check("se_partial_wel_cleared", 8'h00);

        // Reset in the middle of READ data
        spi_cmd(8'h06);
        spi_start();
        spi_byte(8'h03, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'h00, rx);
        check("rst_pre_data", 32'(rx), 32'hC3);
        for (int i = 0; i < 3; i++) spi_bit(1'b0, b);
        check("rst_pre_oe", 32'(miso_oe), 32'd1);
        rst_n = 1'b0;
        #20;
        check("rst_mid_oe", 32'(miso_oe), 32'd0);
        check("rst_mid_miso", 32'(miso), 32'd0);
        check("rst_mid_addr", 32'(mem_addr), 32'd0);
        ncs  = 1'b1;
        sclk = 1'b0;
        #40;
        rst_n = 1'b1;
        #100;
        rdsr_check("rst_wel_fresh_decode", 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
